// File: rtl/float16_mul.sv
// Four-stage float16 multiplier (product stage ahead of float16_add).
// Zero for exp==0, no Inf/NaN, truncating rounding, saturating overflow.
module float16_mul #(
   parameter int EXP_BIAS = 15,
   parameter int LATENCY  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        de_in,
   input  logic [15:0] data_in_01,
   input  logic [15:0] data_in_02,
   output logic        de_out,
   output logic [15:0] data_out
);

   logic [LATENCY-1:0] de_pipe;

   logic [4:0]  s1_exp_a, s1_exp_b;
   logic [9:0]  s1_frac_a, s1_frac_b;
   logic        s1_zero, s1_sign;

   logic [21:0]        s2_prod;
   logic signed [7:0]  s2_exp;
   logic               s2_zero, s2_sign;

   logic [9:0]         s3_frac;
   logic signed [7:0]  s3_exp;
   logic               s3_zero, s3_sign;

   always_ff @(posedge clk) begin
      if (rst) begin
         de_pipe   <= '0;
         s1_exp_a  <= '0;
         s1_exp_b  <= '0;
         s1_frac_a <= '0;
         s1_frac_b <= '0;
         s1_zero   <= 1'b0;
         s1_sign   <= 1'b0;
         s2_prod   <= '0;
         s2_exp    <= '0;
         s2_zero   <= 1'b0;
         s2_sign   <= 1'b0;
         s3_frac   <= '0;
         s3_exp    <= '0;
         s3_zero   <= 1'b0;
         s3_sign   <= 1'b0;
         data_out  <= '0;
      end else begin
         de_pipe <= {de_pipe[LATENCY-2:0], de_in};

         s1_exp_a  <= data_in_01[14:10];
         s1_exp_b  <= data_in_02[14:10];
         s1_frac_a <= data_in_01[9:0];
         s1_frac_b <= data_in_02[9:0];
         s1_zero   <= (data_in_01[14:10] == 5'd0) | (data_in_02[14:10] == 5'd0);
         s1_sign   <= data_in_01[15] ^ data_in_02[15];

         s2_prod <= 22'({1'b1, s1_frac_a}) * 22'({1'b1, s1_frac_b});
         s2_exp  <= $signed({3'b000, s1_exp_a}) + $signed({3'b000, s1_exp_b})
                    - 8'(EXP_BIAS);
         s2_zero <= s1_zero;
         s2_sign <= s1_sign;

         // product of two [1,2) mantissas lies in [1,4): at most one shift
         if (s2_prod[21]) begin
            s3_frac <= s2_prod[20:11];
            s3_exp  <= s2_exp + 8'sd1;
         end else begin
            s3_frac <= s2_prod[19:10];
            s3_exp  <= s2_exp;
         end
         s3_zero <= s2_zero;
         s3_sign <= s2_sign;

         // exp 31 is reserved as the saturation code shared with the adder
         if (s3_zero)
            data_out <= 16'h0000;
         else if (s3_exp >= 8'sd31)
            data_out <= {s3_sign, 5'd31, 10'h3FF};
         else if (s3_exp <= 8'sd0)
            data_out <= 16'h0000;
         else
            data_out <= {s3_sign, s3_exp[4:0], s3_frac};
      end
   end

   assign de_out = de_pipe[LATENCY-1];

endmodule

// File: tb/tb_float16_mul.sv
// Self-checking bench for float16_mul: directed vectors plus random streams
// checked against a real-arithmetic reference model.
module tb_float16_mul;

   logic        clk = 1'b0;
   logic        rst;
   logic        de_in;
   logic [15:0] data_in_01;
   logic [15:0] data_in_02;
   logic        de_out;
   logic [15:0] data_out;

   int n_checks = 0;
   int n_fail   = 0;

   float16_mul dut (
      .clk        (clk),
      .rst        (rst),
      .de_in      (de_in),
      .data_in_01 (data_in_01),
      .data_in_02 (data_in_02),
      .de_out     (de_out),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   // Value-level model: multiply the real mantissas, renormalise by halving,
   // then apply zero / saturation / flush and truncate the fraction.
   function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      int  ex, ey, k, fr;
      real p;
      logic s;
      ex = int'(x[14:10]);
      ey = int'(y[14:10]);
      s  = x[15] ^ y[15];
      if (ex == 0 || ey == 0) return 16'h0000;
      p = (1.0 + real'(int'(x[9:0])) / 1024.0) * (1.0 + real'(int'(y[9:0])) / 1024.0);
      k = ex + ey - 15;
      while (p >= 2.0) begin
         p = p / 2.0;
         k = k + 1;
      end
      if (k >= 31) return {s, 15'h7FFF};
      if (k <= 0) return 16'h0000;
      fr = $rtoi((p - 1.0) * 1024.0);
      return {s, 5'(k), 10'(fr)};
   endfunction

   function automatic logic [15:0] rand_op();
      logic [15:0] v;
      v = 16'($urandom());
      if ($urandom_range(0, 9) == 0) v[14:10] = 5'd0;
      return v;
   endfunction

   task automatic test_reset();
      rst        = 1'b1;
      de_in      = 1'b1;
      data_in_01 = 16'h3C00;
      data_in_02 = 16'h3C00;
      repeat (2) @(negedge clk);
      n_checks++;
      if (de_out !== 1'b0 || data_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_state: de_out=%b data_out=%h, want de_out=0 data_out=0000",
                  de_out, data_out);
      end
      rst   = 1'b0;
      de_in = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         n_checks++;
         if (de_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_stale_de cycle %0d: de_out=%b want 0", c, de_out);
         end
      end
   endtask

   task automatic test_directed();
      logic [15:0] va [13];
      logic [15:0] vb [13];
      logic [15:0] vr [13];
      va = '{16'h3C00, 16'h3E00, 16'hC000, 16'h3C01, 16'h0000, 16'h8000, 16'h5640,
             16'h7800, 16'hF800, 16'h7BFF, 16'h0400, 16'h0400, 16'h0400};
      vb = '{16'h3C00, 16'h3E00, 16'h4200, 16'h3C01, 16'h5640, 16'hC000, 16'h0000,
             16'h7800, 16'h7800, 16'h4000, 16'h0400, 16'h4000, 16'h3C00};
      vr = '{16'h3C00, 16'h4080, 16'hC600, 16'h3C02, 16'h0000, 16'h0000, 16'h0000,
             16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0800, 16'h0400};
      for (int v = 0; v < 13; v++) begin
         @(negedge clk);
         de_in      = 1'b1;
         data_in_01 = va[v];
         data_in_02 = vb[v];
         for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) de_in = 1'b0;
            n_checks++;
            if (de_out !== (c == 4)) begin
               n_fail++;
               $display("FAIL directed_de %h*%h cycle %0d: de_out=%b want %b",
                        va[v], vb[v], c, de_out, (c == 4));
            end
            if (c == 4) begin
               n_checks++;
               if (data_out !== vr[v]) begin
                  n_fail++;
                  $display("FAIL directed_data %h*%h: data_out=%h want %h",
                           va[v], vb[v], data_out, vr[v]);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      localparam int LEN = 25;
      logic        pat [LEN];
      logic [15:0] exp_d [LEN];
      logic        want_de;
      for (int i = 0; i < LEN; i++) pat[i] = (i < 20) ? 1'b1 : 1'b0;
      pat[20] = 1'b1; pat[21] = 1'b0; pat[22] = 1'b1; pat[23] = 1'b1; pat[24] = 1'b0;
      for (int i = 0; i < LEN + 5; i++) begin
         @(negedge clk);
         want_de = (i >= 4 && i - 4 < LEN) ? pat[i-4] : 1'b0;
         n_checks++;
         if (de_out !== want_de) begin
            n_fail++;
            $display("FAIL stream_de cycle %0d: de_out=%b want %b", i, de_out, want_de);
         end
         if (want_de) begin
            n_checks++;
            if (data_out !== exp_d[i-4]) begin
               n_fail++;
               $display("FAIL stream_data item %0d: data_out=%h want %h",
                        i - 4, data_out, exp_d[i-4]);
            end
         end
         if (i < LEN) begin
            de_in      = pat[i];
            data_in_01 = rand_op();
            data_in_02 = rand_op();
            exp_d[i]   = ref_mul(data_in_01, data_in_02);
         end else begin
            de_in = 1'b0;
         end
      end
   endtask

   task automatic test_random_traffic();
      localparam int LEN = 60;
      logic        pat [LEN];
      logic [15:0] exp_d [LEN];
      logic        want_de;
      for (int i = 0; i < LEN + 5; i++) begin
         @(negedge clk);
         want_de = (i >= 4 && i - 4 < LEN) ? pat[i-4] : 1'b0;
         n_checks++;
         if (de_out !== want_de) begin
            n_fail++;
            $display("FAIL random_de cycle %0d: de_out=%b want %b", i, de_out, want_de);
         end
         if (want_de) begin
            n_checks++;
            if (data_out !== exp_d[i-4]) begin
               n_fail++;
               $display("FAIL random_data item %0d: data_out=%h want %h",
                        i - 4, data_out, exp_d[i-4]);
            end
         end
         if (i < LEN) begin
            pat[i]     = 1'($urandom_range(0, 1));
            de_in      = pat[i];
            data_in_01 = rand_op();
            data_in_02 = rand_op();
            exp_d[i]   = ref_mul(data_in_01, data_in_02);
         end else begin
            de_in = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         de_in      = 1'b1;
         data_in_01 = 16'h4000 + 16'(i);
         data_in_02 = 16'h4200;
      end
      @(negedge clk);
      rst   = 1'b1;
      de_in = 1'b0;
      @(negedge clk);
      n_checks++;
      if (de_out !== 1'b0 || data_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_mid_flush: de_out=%b data_out=%h, want de_out=0 data_out=0000",
                  de_out, data_out);
      end
      rst        = 1'b0;
      de_in      = 1'b1;
      data_in_01 = 16'h3E00;
      data_in_02 = 16'h3E00;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) de_in = 1'b0;
         n_checks++;
         if (de_out !== (c == 4)) begin
            n_fail++;
            $display("FAIL reset_mid_de cycle %0d: de_out=%b want %b", c, de_out, (c == 4));
         end
         if (c == 4) begin
            n_checks++;
            if (data_out !== 16'h4080) begin
               n_fail++;
               $display("FAIL reset_mid_data: data_out=%h want 4080", data_out);
            end
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      de_in      = 1'b0;
      data_in_01 = 16'h0000;
      data_in_02 = 16'h0000;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random_traffic();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/float16_mul.md
Name: float16_mul

Overview:
Pipelined half-precision multiplier: the product stage of the convolution datapath that feeds float16_add.
- Multiplies pixel × weight pairs and emits the result with a data-enable aligned to the fixed pipeline latency.
- Uses the same number model as the adder:
  - exp==0 means zero; no denormals.
  - exp==31 is an ordinary finite exponent; no Inf/NaN.
  - Rounding is truncation.
  - Overflow saturates to the largest magnitude.
- Accepts one operand pair per clock, with no backpressure.

Parameters:
EXP_BIAS  15  exponent bias of the float16 format; fixed at 15, not to be overridden.
LATENCY   4   de_in→de_out delay in clocks; informational only; RTL is built for exactly 4.

Ports:
clk         input   1   rising-edge clock
rst         input   1   synchronous active-high reset
de_in       input   1   operand pair valid this cycle
data_in_01  input   16  operand A: sign[15], exp[14:10], frac[9:0]
data_in_02  input   16  operand B, same format
de_out      output  1   data_out valid; equals de_in delayed 4 clocks
data_out    output  16  product A×B, same format

Behaviour:
- Reset: rst sampled high at a posedge clears every register on that edge.
  - Next cycle: de_out=0, data_out=16'h0000.
  - Reset mid-stream discards all in-flight operands; no stale de_out may appear after rst is released.
- Datapath runs every cycle regardless of de_in; de_in only travels down the 4-deep valid shift register. Any data_out without de_out is don't-care.
- Latency: de_in and operands sampled at edge N → de_out/data_out valid after edge N+4. Full throughput, one result per clock.
- Stage 1: register the operands.
  - zero_flag = (expA==0) | (expB==0).
  - sign = signA ^ signB.
- Stage 2:
  - mant_prod[21:0] = {1,fracA} × {1,fracB}, unsigned 11×11.
  - exp_sum = expA + expB − EXP_BIAS, as an 8-bit signed value (range −15..47).
- Stage 3: normalise.
  - If mant_prod[21]: frac = mant_prod[20:11], exp_n = exp_sum + 1.
  - Else: frac = mant_prod[19:10], exp_n = exp_sum.
  - Low bits are discarded (truncation, no rounding).
- Stage 4: output register, priority order:
  1. zero_flag → 16'h0000 (sign forced 0; −0 inputs also give +0).
  2. exp_n ≥ 31 → {sign, 5'd31, 10'h3FF} (saturation, same encoding as the adder's overflow).
  3. exp_n ≤ 0 → 16'h0000 (underflow flush).
  4. Otherwise → {sign, exp_n[4:0], frac}.
- Boundaries:
  - exp_n = 31 exactly saturates. The adder treats exp 31 as the saturation value, so the multiplier never emits exp 31 with any frac other than 3FF.
  - exp_n = 1 is a valid normal result.
  - de_in held high continuously → de_out high continuously 4 clocks later.
  - de_in toggling → de_out reproduces the same pattern.

Test Plan:
1. 1.0×1.0: 3C00×3C00 with de_in pulse at edge N → de_out high only after edge N+4, data_out=3C00. de_out=0 on all other cycles.
2. Normalise path, mant_prod[21]=1: 3E00×3E00 (1.5×1.5) → 4080 (2.25). Sign and truncation: C000×4200 → C600 (−6). 3C01×3C01 → 3C02 (low bits truncated).
3. Zero handling: 0000×5640 → 0000; 8000×C000 → 0000; 5640×0000 → 0000.
4. Saturation/underflow:
   - 7800×7800 → 7FFF; F800×7800 → FFFF.
   - 7BFF×4000 → 7FFF (exp_n=31 edge).
   - 0400×0400 → 0000.
   - 0400×4000 → 0800 (exp_n=2).
5. Streaming: 20 back-to-back pairs with de_in=1 every cycle, then a 1-0-1-1-0 de_in pattern → results in order against a golden model, each with a 4-cycle offset; de_out pattern identical to de_in.
6. Reset mid-operation: 3 valid pairs in flight, rst high for 1 cycle → de_out=0 and data_out=0000 the next cycle. No de_out for the flushed pairs afterwards. A new pair issued right after reset gives a correct result 4 clocks later.
